stream_transpose: RTL and testbench



---
 rtl/stream_transpose.sv | 114 +++++++++++
 tb/tb_stream_transpose.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stream_transpose.sv
// Streaming ROWS x COLS matrix transposer with ping-pong banks. Each bank holds
// one matrix plus its latched mode; the write side fills one while the read side drains the other.
module stream_transpose_lane #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int CW     = 2,
  parameter int LANE   = 0
) (
  input  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] bank,
  input  logic [CW-1:0]                         beat,
  input  logic                                  mode,
  input  logic                                  en,
  output logic [DATA_W-1:0]                     elem
);
  // Transpose picks M[LANE][beat]; pass-through picks M[beat][LANE]. Lanes outside the shape stay zero.
  always_comb begin
    elem = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (en && (mode ? (r == LANE && CW'(c) == beat) : (CW'(r) == beat && c == LANE)))
          elem = bank[r][c];
  end
endmodule

module stream_transpose #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  localparam int MAXW  = (ROWS > COLS) ? ROWS : COLS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [COLS*DATA_W-1:0]   in_row,
  input  logic                     in_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MAXW*DATA_W-1:0]   out_row,
  output logic                     out_last
);
  localparam int CW = $clog2(MAXW);
  localparam int RW = $clog2(ROWS);
  localparam bit SQUARE = (ROWS == COLS);
  localparam logic [CW-1:0] LAST_T = CW'(COLS - 1);
  localparam logic [CW-1:0] LAST_P = CW'(ROWS - 1);
  localparam logic [RW-1:0] LAST_W = RW'(ROWS - 1);

  logic [1:0][ROWS-1:0][COLS-1:0][DATA_W-1:0] mem;
  logic [1:0]          full;
  logic [1:0]          mode_q;
  logic                wr_bank, rd_bank;
  logic [RW-1:0]       wr_cnt;
  logic [CW-1:0]       rd_cnt;
  logic                wr_fire, rd_fire, cur_mode;
  logic [MAXW-1:0][DATA_W-1:0] lanes;

  assign in_ready  = !full[wr_bank] && !rst;
  assign wr_fire   = in_valid && in_ready;
  assign out_valid = full[rd_bank];
  assign rd_fire   = out_valid && out_ready;
  assign cur_mode  = mode_q[rd_bank];
  assign out_last  = out_valid && (rd_cnt == (cur_mode ? LAST_T : LAST_P));
  assign out_row   = lanes;

  // Payload storage carries no reset; full flags gate everything read from it.
  always_ff @(posedge clk)
    if (wr_fire) mem[wr_bank][wr_cnt] <= in_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= '0;
      mode_q  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) mode_q[wr_bank] <= SQUARE ? in_mode : 1'b1;
        if (wr_cnt == LAST_W) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      // A write only targets a non-full bank, so this clear never collides with the set above.
      if (rd_fire) begin
        if (out_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < MAXW; k++) begin : g_lane
    stream_transpose_lane #(
      .DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .CW(CW), .LANE(k)
    ) u_lane (
      .bank (mem[rd_bank]),
      .beat (rd_cnt),
      .mode (cur_mode),
      .en   (out_valid),
      .elem (lanes[k])
    );
  end
endmodule

// File: tb/tb_stream_transpose.sv
// Directed bench: a 4x4x8 instance for transpose/stream/backpressure/mode/reset
// and a 2x3x16 instance for the forced-transpose rectangular case.
module tb_stream_transpose;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 0, in_mode = 0, out_ready = 0;
  logic [31:0] in_row = '0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_row;

  logic        b_in_valid = 0, b_in_mode = 0, b_out_ready = 0;
  logic [47:0] b_in_row = '0;
  logic        b_in_ready, b_out_valid, b_out_last;
  logic [47:0] b_out_row;

  int tests = 0;
  int fails = 0;

  stream_transpose #(.DATA_W(8), .ROWS(4), .COLS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last));

  stream_transpose #(.DATA_W(16), .ROWS(2), .COLS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row),
    .in_mode(b_in_mode), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
    .out_last(b_out_last));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Element (m,r,c) = m*64 + r*16 + 0x0A + c, so matrix 0 row 0 is 0x0D0C0B0A.
  function automatic logic [31:0] row_of(int m, int r);
    logic [31:0] v;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(m*64 + r*16 + 10 + c);
    return v;
  endfunction

  function automatic logic [31:0] col_of(int m, int k);
    logic [31:0] v;
    for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(m*64 + r*16 + 10 + k);
    return v;
  endfunction

  // Back-to-back matrices base..base+nmat-1 with out_ready high; checks both sides every cycle.
  task automatic run_stream(input int base, input int nmat, input logic [3:0] modes, input bit toggle);
    int j, m;
    out_ready = 1'b1;
    for (int t = 0; t <= nmat*4 + 4; t++) begin
      if (t < nmat*4) begin
        chk("stream_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_row   = row_of(base + t/4, t%4);
        in_mode  = (t%4 == 0) ? modes[t/4] : (toggle ? ~modes[t/4] : modes[t/4]);
      end else begin
        in_valid = 1'b0;
      end
      j = t - 4;
      if (j >= 0 && j < nmat*4) begin
        m = j / 4;
        chk("stream_valid", 64'(out_valid), 64'd1);
        chk("stream_row", 64'(out_row), modes[m] ? 64'(col_of(base + m, j%4)) : 64'(row_of(base + m, j%4)));
        chk("stream_last", 64'(out_last), 64'(j%4 == 3));
      end else begin
        chk("stream_idle", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_row", 64'(out_row), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    rst = 1'b0;
    #1 chk("rel_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Single 4x4 transpose with explicit vectors
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("single_pre_valid", 64'(out_valid), 64'd0);
      in_valid = 1'b1;
      in_mode  = 1'b1;
      in_row   = (i == 0) ? 32'h0D0C0B0A : (i == 1) ? 32'h1D1C1B1A : (i == 2) ? 32'h2D2C2B2A : 32'h3D3C3B3A;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_row", 64'(out_row),
          (k == 0) ? 64'h3A2A1A0A : (k == 1) ? 64'h3B2B1B0B : (k == 2) ? 64'h3C2C1C0C : 64'h3D2D1D0D);
      chk("single_last", 64'(out_last), 64'(k == 3));
      @(negedge clk);
    end
    chk("single_done", 64'(out_valid), 64'd0);
    chk("single_masked", 64'(out_row), 64'd0);

    // Streaming: three back-to-back transposes
    run_stream(0, 3, 4'b0111, 1'b0);

    // Backpressure: two matrices buffered, third stalls
    out_ready = 1'b0;
    in_mode   = 1'b1;
    for (int t = 0; t < 8; t++) begin
      chk("bp_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_row   = row_of(t/4, t%4);
      @(negedge clk);
    end
    in_row = row_of(2, 0);
    for (int h = 0; h < 3; h++) begin
      chk("bp_full", 64'(in_ready), 64'd0);
      chk("bp_hold_row", 64'(out_row), 64'h3A2A1A0A);
      chk("bp_hold_last", 64'(out_last), 64'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_row", 64'(out_row), 64'(col_of(j/4, j%4)));
      chk("bp_last", 64'(out_last), 64'(j%4 == 3));
      @(negedge clk);
    end
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_ready_back", 64'(in_ready), 64'd1);

    // Mode: A pass-through, B transpose, in_mode toggled mid-matrix
    run_stream(0, 2, 4'b0010, 1'b1);

    // Reset mid-matrix discards partial data
    in_mode = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_row   = row_of(3, i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1 chk("mid_rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("mid_rst_valid2", 64'(out_valid), 64'd0);
    run_stream(2, 1, 4'b0001, 1'b0);

    // Rectangular 2x3x16, pass-through request forced to transpose
    b_out_ready = 1'b1;
    chk("rect_ready", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1;
    b_in_mode  = 1'b0;
    b_in_row   = 48'h000C_000B_000A;
    @(negedge clk);
    chk("rect_pre_valid", 64'(b_out_valid), 64'd0);
    b_in_row = 48'h001C_001B_001A;
    @(negedge clk);
    b_in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rect_valid", 64'(b_out_valid), 64'd1);
      chk("rect_row", 64'(b_out_row),
          (k == 0) ? 64'h0000_001A_000A : (k == 1) ? 64'h0000_001B_000B : 64'h0000_001C_000C);
      chk("rect_last", 64'(b_out_last), 64'(k == 2));
      @(negedge clk);
    end
    chk("rect_done", 64'(b_out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
